// File: rtl/rf_wb_sched_pkg.sv
// Shared types for the register-file writeback scheduler.
// Re-exports the defs.vh widths as localparams and defines the registered
// writeback record (enable, source tag, address, data).
`include "defs.vh"

package rf_wb_sched_pkg;

  localparam int XLEN       = `XLEN;
  localparam int REG_ADDR_W = `REG_ADDR_W;
  localparam int REG_COUNT  = `REG_COUNT;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_COUNT-1:0]  busy_vec_t;

  // One registered writeback. src distinguishes pipeline (p0) from the
  // long-latency unit (p1); only p1 commits release a scoreboard entry.
  typedef struct packed {
    logic      we;
    logic      src;
    reg_addr_t addr;
    xlen_t     data;
  } wb_t;

  // p1 wins when p0 is idle, or when p0 has used up its starvation allowance.
  function automatic logic grant_p1(input logic p0_vld, input logic p1_vld,
                                    input logic starve_hit);
    return p1_vld & (~p0_vld | starve_hit);
  endfunction

endpackage

// File: rtl/defs.vh
`ifndef RF_WB_SCHED_DEFS_VH
`define RF_WB_SCHED_DEFS_VH

`define XLEN       32
`define REG_ADDR_W 5
`define REG_COUNT  32
`define REG_ZERO   5'd0

`define WB_SRC_P0  1'b0
`define WB_SRC_P1  1'b1

`endif

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations plus decode hazard lookup.
// Ports: clk/rst_n; set_vld_i/set_addr_i reserve an entry; clr_vld_i/clr_addr_i
// release one; chk_a_i/chk_b_i lookup; busy_vec_o state; hazard_o combinational.
`include "defs.vh"

module rf_scoreboard
  import rf_wb_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_vld_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_vld_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t chk_a_i,
  input  reg_addr_t chk_b_i,
  output busy_vec_t busy_vec_o,
  output logic      hazard_o
);

  busy_vec_t busy_q, busy_d;

  // Clear is applied first so a same-cycle reservation of the same register
  // wins: the new long-latency op still owns the destination.
  always_comb begin
    busy_d = busy_q;
    if (clr_vld_i) busy_d[clr_addr_i] = 1'b0;
    if (set_vld_i) busy_d[set_addr_i] = 1'b1;
    busy_d[`REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;
  assign hazard_o   = busy_q[chk_a_i] | busy_q[chk_b_i];

endmodule

// File: rtl/rf_wb_sched.sv
// Two-source register-file writeback arbiter with a busy-bit scoreboard.
// Ports: p0 (pipeline) and p1 (long-latency) valid/ready write requests,
// rsv_* reservation, chk_addr_* hazard lookup, rf_* registered write port,
// busy_vec scoreboard state. Write port latency is one cycle.
`include "defs.vh"

module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_valid,
  output logic                   p0_ready,
  input  logic [`REG_ADDR_W-1:0] p0_addr,
  input  logic [`XLEN-1:0]       p0_data,
  input  logic                   p1_valid,
  output logic                   p1_ready,
  input  logic [`REG_ADDR_W-1:0] p1_addr,
  input  logic [`XLEN-1:0]       p1_data,
  input  logic                   rsv_valid,
  input  logic [`REG_ADDR_W-1:0] rsv_addr,
  input  logic [`REG_ADDR_W-1:0] chk_addr_a,
  input  logic [`REG_ADDR_W-1:0] chk_addr_b,
  output logic                   hazard,
  output logic                   rf_we,
  output logic [`REG_ADDR_W-1:0] rf_waddr,
  output logic [`XLEN-1:0]       rf_wdata,
  output logic [`REG_COUNT-1:0]  busy_vec
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  wb_t        wb_q, wb_d;
  logic       starve_hit;
  logic       p0_gnt, p1_gnt;
  logic       p0_xfer, p1_xfer;
  logic       p1_commit;

  // ---------------------------------------------------------------------------
  // Arbitration: p0 by default, p1 on idle p0 or exhausted starvation budget.
  // Ready is masked by reset so nothing is accepted while held in reset.
  // ---------------------------------------------------------------------------
  assign starve_hit = (starve_cnt_q == STARVE_LIM);
  assign p1_gnt     = grant_p1(p0_valid, p1_valid, starve_hit);
  assign p0_gnt     = p0_valid & ~p1_gnt;

  assign p0_ready = rst_n & p0_gnt;
  assign p1_ready = rst_n & p1_gnt;
  assign p0_xfer  = p0_valid & p0_ready;
  assign p1_xfer  = p1_valid & p1_ready;

  // Counts p0 wins while p1 is kept waiting; any p1 win or p1 going idle
  // resets the allowance.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (p1_xfer || !p1_valid) begin
      starve_cnt_d = '0;
    end else if (p0_xfer && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback register. Address/data hold their last value between writes;
  // only the enable pulses. Writes to the zero register are accepted upstream
  // but never enabled toward the register file.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    if (p1_xfer) begin
      wb_d.we   = (p1_addr != `REG_ZERO);
      wb_d.src  = `WB_SRC_P1;
      wb_d.addr = p1_addr;
      wb_d.data = p1_data;
    end else if (p0_xfer) begin
      wb_d.we   = (p0_addr != `REG_ZERO);
      wb_d.src  = `WB_SRC_P0;
      wb_d.addr = p0_addr;
      wb_d.data = p0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      wb_q         <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_q         <= wb_d;
    end
  end

  assign rf_we    = wb_q.we;
  assign rf_waddr = wb_q.addr;
  assign rf_wdata = wb_q.data;

  // A long-latency result releases its destination as it lands in the RF.
  assign p1_commit = wb_q.we & (wb_q.src == `WB_SRC_P1);

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_vld_i  (rsv_valid),
    .set_addr_i (rsv_addr),
    .clr_vld_i  (p1_commit),
    .clr_addr_i (wb_q.addr),
    .chk_a_i    (chk_addr_a),
    .chk_b_i    (chk_addr_b),
    .busy_vec_o (busy_vec),
    .hazard_o   (hazard)
  );

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched with a reference arbiter/scoreboard model.
// Expected writebacks are queued at grant time and popped one cycle later.
// Inputs change 1ns after posedge; readies/hazard/busy checked at negedge.
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p1_valid, rsv_valid;
  logic        p0_ready, p1_ready, hazard, rf_we;
  logic [4:0]  p0_addr, p1_addr, rsv_addr, chk_addr_a, chk_addr_b, rf_waddr;
  logic [31:0] p0_data, p1_data, rf_wdata, busy_vec;

  rf_wb_sched #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        src;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          cur_vld = 1'b0;
  logic [31:0] m_busy = '0;
  int          m_starve = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          last_gnt = 0;   // 0 none, 1 p0, 2 p1 (observed from DUT)
  int          grants[10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit eg0, eg1;
    @(negedge clk);
    eg1 = rst_n && p1_valid && (!p0_valid || m_starve == SM);
    eg0 = rst_n && p0_valid && !(p1_valid && (!p0_valid || m_starve == SM));
    chk("p0_ready", 64'(p0_ready), 64'(eg0));
    chk("p1_ready", 64'(p1_ready), 64'(eg1));
    chk("hazard", 64'(hazard), 64'(m_busy[chk_addr_a] | m_busy[chk_addr_b]));
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    last_gnt = p0_ready ? 1 : (p1_ready ? 2 : 0);
    @(posedge clk);
    if (!rst_n) begin
      m_busy = '0;
      m_starve = 0;
      q.delete();
    end else begin
      if (cur_vld && cur.we && cur.src) m_busy[cur.addr] = 1'b0;
      if (rsv_valid && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
      if (eg1 || !p1_valid) m_starve = 0;
      else if (eg0 && m_starve < SM) m_starve++;
      if (eg1)      q.push_back('{(p1_addr != 5'd0), 1'b1, p1_addr, p1_data});
      else if (eg0) q.push_back('{(p0_addr != 5'd0), 1'b0, p0_addr, p0_data});
    end
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      cur_vld = 1'b1;
      chk("rf_we", 64'(rf_we), 64'(cur.we));
      chk("rf_waddr", 64'(rf_waddr), 64'(cur.addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(cur.data));
    end else begin
      cur_vld = 1'b0;
      chk("rf_we_idle", 64'(rf_we), 64'd0);
    end
  endtask

  task automatic idle_inputs();
    p0_valid = 1'b0; p1_valid = 1'b0; rsv_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0; rsv_valid = 1'b0;
    p0_addr = '0; p1_addr = '0; rsv_addr = '0; chk_addr_a = '0; chk_addr_b = '0;
    p0_data = '0; p1_data = '0;

    // Reset: readies forced low even with requests pending.
    p0_valid = 1'b1; p1_valid = 1'b1; p0_addr = 5'd4; p1_addr = 5'd6;
    step();
    step();
    rst_n = 1'b1; idle_inputs();
    step();
    chk("reset_busy", 64'(busy_vec), 64'd0);

    // Single p0 write: x3 <= 0x11 one cycle later.
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h11;
    step();
    chk("p0_we_x3", 64'(rf_we), 64'd1);
    chk("p0_waddr_x3", 64'(rf_waddr), 64'd3);
    chk("p0_wdata_x3", 64'(rf_wdata), 64'h11);

    // Both requesters held valid: four p0 grants then one p1, repeating.
    p0_valid = 1'b1; p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'hA5A5_0009;
    for (int i = 0; i < 10; i++) begin
      p0_addr = 5'(10 + i); p0_data = 32'h100 + 32'(i);
      step();
      grants[i] = last_gnt;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_pattern_%0d", i), 64'(grants[i]), (i % 5 == 4) ? 64'd2 : 64'd1);
    idle_inputs();
    step();

    // Reserve x5; hazard held until the cycle after the p1 write to x5 lands.
    rsv_valid = 1'b1; rsv_addr = 5'd5; chk_addr_a = 5'd5; chk_addr_b = 5'd1;
    step();
    rsv_valid = 1'b0;
    step();
    chk("hazard_x5_pending", 64'(hazard), 64'd1);
    p1_valid = 1'b1; p1_addr = 5'd5; p1_data = 32'h5555;
    step();
    p1_valid = 1'b0;
    chk("hazard_x5_commit_cycle", 64'(hazard), 64'd1);
    step();
    chk("hazard_x5_released", 64'(hazard), 64'd0);

    // Reservation of x7 coinciding with the p1 commit to x7 keeps it busy.
    rsv_valid = 1'b1; rsv_addr = 5'd7; chk_addr_a = 5'd7;
    step();
    rsv_valid = 1'b0; p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'h7777;
    step();
    p1_valid = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_valid = 1'b0;
    step();
    chk("busy7_set_priority", 64'(busy_vec[7]), 64'd1);

    // p1 write to x0: accepted, no RF write, scoreboard untouched.
    p1_valid = 1'b1; p1_addr = 5'd0; p1_data = 32'hFF;
    step();
    p1_valid = 1'b0;
    chk("x0_no_we", 64'(rf_we), 64'd0);
    chk("x0_busy_kept", 64'(busy_vec), 64'h0000_0080);

    // Back-to-back p0 writes, including one to x0, no bubbles.
    p0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p0_addr = (i == 3) ? 5'd0 : 5'(20 + i);
      p0_data = $urandom;
      step();
    end
    idle_inputs();
    step();

    // Reset asserted during a p0 request: dropped, scoreboard cleared.
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    step();
    rsv_valid = 1'b0; p0_valid = 1'b1; p0_addr = 5'd2; p0_data = 32'h22; rst_n = 1'b0;
    step();
    chk("rst_drop_we", 64'(rf_we), 64'd0);
    chk("rst_busy_clr", 64'(busy_vec), 64'd0);
    rst_n = 1'b1; idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
